// File: rtl/m16_pkg.sv
// Shared types and constants for the M_16 counter run controller.
package m16_pkg;

  // Default counter width.
  localparam int W_DEF = 16;

  // Width of the counter's parallel-load data bus.
  localparam int D_W = 4;

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Registered counter controls; enable is kept out because it is combinational.
  typedef struct packed {
    logic           clr;
    logic           pe;
    logic           flag;
    logic [D_W-1:0] d;
  } cnt_ctrl_t;

  // Counter controls presented while the controller sits in state s.
  function automatic cnt_ctrl_t decode_ctrl(input state_t s, input logic up,
                                            input logic [D_W-1:0] d);
    cnt_ctrl_t c;
    c      = '0;
    c.clr  = (s == S_CLEAR);
    c.pe   = (s == S_LOAD);
    c.flag = (s != S_IDLE) ? up : 1'b0;
    c.d    = (s == S_LOAD) ? d : '0;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// W-bit up counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles; clear wins over enable, saturate instead of wrapping.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only, so it lives inside the clocked branch.
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      // NOTE: sequential state always uses non-blocking assignment so every flop sees pre-edge values.
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/m16_run_ctrl.sv
// Run sequencer for the M_16 cascaded counter: clear, optional load, count to target, report.
module m16_run_ctrl
  import m16_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           CP,
  input  logic           CLR,
  input  logic           start,
  input  logic           abort,
  input  logic           pause,
  input  logic           up,
  input  logic           load_en,
  input  logic [D_W-1:0] d_in,
  input  logic [W-1:0]   target,
  input  logic [W-1:0]   q_in,
  output logic           cnt_clr,
  output logic           cnt_pe,
  output logic           cnt_en,
  output logic           cnt_flag,
  output logic [D_W-1:0] cnt_d,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   run_cycles
);

  state_t         state;
  state_t         state_next;

  // Run parameters captured at start.
  logic           up_q;
  logic           load_en_q;
  logic [D_W-1:0] d_q;
  logic [W-1:0]   target_q;

  // Values the captured parameters take after this edge.
  logic           up_next;
  logic           load_en_next;
  logic [D_W-1:0] d_next;
  logic [W-1:0]   target_next;

  logic           latch_now;
  logic           at_target;
  cnt_ctrl_t      ctrl_q;

  // A start request only counts while idle; it also opens a new run_cycles window.
  assign latch_now = (state == S_IDLE) && start;
  assign at_target = (q_in == target_q);

  // Enable is combinational so the counter stops on the very cycle Q hits the target.
  assign cnt_en = (state == S_RUN) && !pause && !at_target;

  assign cnt_clr  = ctrl_q.clr;
  assign cnt_pe   = ctrl_q.pe;
  assign cnt_flag = ctrl_q.flag;
  assign cnt_d    = ctrl_q.d;

  // Capture-at-start mux for the run parameters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    up_next      = up_q;
    load_en_next = load_en_q;
    d_next       = d_q;
    target_next  = target_q;
    if (latch_now) begin
      up_next      = up;
      load_en_next = load_en;
      d_next       = d_in;
      target_next  = target;
    end
  end

  // Next-state logic; abort overrides every normal transition out of a busy state.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_CLEAR;
      S_CLEAR: state_next = load_en_q ? S_LOAD : S_RUN;
      S_LOAD:  state_next = S_RUN;
      S_RUN:   if (at_target) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_next = S_IDLE;
    end
  end

  // State, captured parameters and registered outputs, all decoded from the next state.
  always_ff @(posedge CP) begin
    if (!CLR) begin
      state     <= S_IDLE;
      up_q      <= 1'b0;
      load_en_q <= 1'b0;
      d_q       <= '0;
      target_q  <= '0;
      ctrl_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      up_q      <= up_next;
      load_en_q <= load_en_next;
      d_q       <= d_next;
      target_q  <= target_next;
      ctrl_q    <= decode_ctrl(state_next, up_next, d_next);
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
    end
  end

  // Enabled-cycle counter for the current or most recent run.
  sat_counter #(
    .W (W)
  ) u_run_cycles (
    .clk   (CP),
    .rst_n (CLR),
    .clr   (latch_now),
    .en    (cnt_en),
    .count (run_cycles)
  );

endmodule

// File: tb/tb_m16_run_ctrl.sv
// Bench for m16_run_ctrl driving a behavioural M_16 counter model; done pulses checked by a scoreboard.
module tb_m16_run_ctrl;
  import m16_pkg::*;

  logic        CP      = 1'b0;
  logic        CLR     = 1'b0;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic        pause   = 1'b0;
  logic        up      = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  d_in    = 4'h0;
  logic [15:0] target  = 16'h0000;
  logic [15:0] q_in;
  logic        cnt_clr, cnt_pe, cnt_en, cnt_flag, busy, done;
  logic [3:0]  cnt_d;
  logic [15:0] run_cycles;

  m16_run_ctrl #(.W(16)) dut (
    .CP         (CP),
    .CLR        (CLR),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .up         (up),
    .load_en    (load_en),
    .d_in       (d_in),
    .target     (target),
    .q_in       (q_in),
    .cnt_clr    (cnt_clr),
    .cnt_pe     (cnt_pe),
    .cnt_en     (cnt_en),
    .cnt_flag   (cnt_flag),
    .cnt_d      (cnt_d),
    .busy       (busy),
    .done       (done),
    .run_cycles (run_cycles)
  );

  always #5 CP = ~CP;

  // Behavioural M_16: clear beats load beats count.
  logic [15:0] q_model = 16'h1234;
  assign q_in = q_model;
  always @(posedge CP) begin
    if (cnt_clr)     q_model <= 16'h0000;
    else if (cnt_pe) q_model <= {12'h000, cnt_d};
    else if (cnt_en) q_model <= cnt_flag ? q_model + 16'd1 : q_model - 16'd1;
  end

  int cyc = 0;
  int en_count = 0;
  always @(posedge CP) begin
    cyc <= cyc + 1;
    if (cnt_en === 1'b1) en_count <= en_count + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] cycles;
    logic [15:0] q;
    int          edge_at;
  } exp_t;
  exp_t exp_q[$];

  int start_edge = 0;

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge CP) begin
    exp_t e;
    if (CLR && (done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_run_cycles", run_cycles, e.cycles);
        check("done_q", q_in, e.q);
        check("done_latency", cyc, e.edge_at);
      end
    end
  end

  task automatic push_exp(input logic [15:0] cycles, input logic [15:0] q, input int lat);
    exp_t e;
    e.cycles  = cycles;
    e.q       = q;
    e.edge_at = start_edge + lat;
    exp_q.push_back(e);
  endtask

  // Issue start; returns at the negedge of the CLEAR cycle with inputs scrambled to prove capture.
  task automatic run_start(input logic lden, input logic dir, input logic [3:0] d,
                           input logic [15:0] tgt);
    @(negedge CP);
    load_en = lden;
    up      = dir;
    d_in    = d;
    target  = tgt;
    start   = 1'b1;
    @(negedge CP);
    start      = 1'b0;
    start_edge = cyc;
    load_en    = ~lden;
    up         = ~dir;
    d_in       = 4'hF;
    target     = 16'hBEEF;
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CP);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  task automatic wait_q(input logic [15:0] val, input int budget, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CP);
      if (q_in == val) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       busy,       1'b0);
    check({tag, "_done"},       done,       1'b0);
    check({tag, "_cnt_clr"},    cnt_clr,    1'b0);
    check({tag, "_cnt_pe"},     cnt_pe,     1'b0);
    check({tag, "_cnt_en"},     cnt_en,     1'b0);
    check({tag, "_cnt_flag"},   cnt_flag,   1'b0);
    check({tag, "_cnt_d"},      cnt_d,      4'h0);
    check({tag, "_run_cycles"}, run_cycles, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_before;

    // Reset state.
    CLR = 1'b0;
    repeat (2) @(negedge CP);
    check_all_zero("reset");
    CLR = 1'b1;

    // Up run: load 9, count to 0x19 (16 counts, RUN lasts 17 cycles).
    run_start(1'b1, 1'b1, 4'h9, 16'h0019);
    push_exp(16'd16, 16'h0019, 19);
    check("up_clear_cycle_clr", cnt_clr, 1'b1);
    check("up_clear_cycle_pe", cnt_pe, 1'b0);
    check("up_clear_busy", busy, 1'b1);
    check("up_clear_flag", cnt_flag, 1'b1);
    @(negedge CP);
    check("up_load_clr", cnt_clr, 1'b0);
    check("up_load_pe", cnt_pe, 1'b1);
    check("up_load_d", cnt_d, 4'h9);
    @(negedge CP);
    check("up_run_pe", cnt_pe, 1'b0);
    check("up_run_d", cnt_d, 4'h0);
    check("up_run_q", q_in, 16'h0009);
    check("up_run_en", cnt_en, 1'b1);
    wait_idle(40, "up_wait_idle");
    repeat (2) @(negedge CP);
    check("up_q_hold", q_in, 16'h0019);
    check("up_cycles_hold", run_cycles, 16'd16);
    check("up_idle_flag", cnt_flag, 1'b0);

    // Down run without load, wrapping 0 -> FFFF -> FFFE -> FFFD.
    run_start(1'b0, 1'b0, 4'h3, 16'hFFFD);
    push_exp(16'd3, 16'hFFFD, 5);
    check("down_clear_clr", cnt_clr, 1'b1);
    check("down_clear_flag", cnt_flag, 1'b0);
    @(negedge CP);
    check("down_no_load_pe", cnt_pe, 1'b0);
    check("down_run_q", q_in, 16'h0000);
    check("down_run_en", cnt_en, 1'b1);
    wait_idle(20, "down_wait_idle");

    // Pause for 4 cycles mid-run: same totals, done 4 cycles later.
    run_start(1'b1, 1'b1, 4'h9, 16'h0019);
    push_exp(16'd16, 16'h0019, 23);
    wait_q(16'h0010, 40, "pause_reach_q");
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CP);
      check("pause_q_frozen", q_in, 16'h0010);
      check("pause_en_low", cnt_en, 1'b0);
    end
    pause = 1'b0;
    wait_idle(40, "pause_wait_idle");

    // Abort in RUN, with an ignored second start first.
    run_start(1'b0, 1'b1, 4'h0, 16'h0100);
    wait_q(16'h0005, 20, "abort_reach_q");
    load_en = 1'b1;
    start   = 1'b1;
    @(negedge CP);
    start = 1'b0;
    check("busy_start_no_clr", cnt_clr, 1'b0);
    check("busy_start_no_pe", cnt_pe, 1'b0);
    check("busy_start_busy", busy, 1'b1);
    check("busy_start_q_counts", q_in, 16'h0006);
    abort = 1'b1;
    @(negedge CP);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_en", cnt_en, 1'b0);
    check("abort_flag", cnt_flag, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (3) begin
      @(negedge CP);
      check("abort_q_held", q_in, 16'h0007);
    end

    // Reset for one cycle mid-run.
    run_start(1'b1, 1'b1, 4'h9, 16'h0019);
    wait_q(16'h000C, 20, "rst_reach_q");
    CLR = 1'b0;
    @(negedge CP);
    CLR = 1'b1;
    check_all_zero("midrst");

    // New run after reset: target equals loaded value, counter never enabled.
    en_before = en_count;
    run_start(1'b1, 1'b1, 4'h5, 16'h0005);
    push_exp(16'd0, 16'h0005, 3);
    wait_idle(20, "imm_wait_idle");
    check("imm_no_enable", en_count - en_before, 32'd0);

    repeat (3) @(negedge CP);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m16_run_ctrl.md
# m16_run_ctrl

Sequencer for the 16-bit cascaded counter (M_16). It drives the counter's clear, parallel-load, enable and direction (`flag`) controls, then runs the counter from a loaded start value until its output `Q` equals a programmed target. It then reports completion and the number of enabled count cycles. It sits between the board-level control inputs (buttons/switches) and the counter, replacing hand-driven control of `EN_0`, `PE`, `CLR` and `flag`.

## Interface
Parameters:
- `W`, 16: counter width; `q_in` and `target` widths.

Ports:
- `CP`, in, 1: clock; all state updates on the rising edge.
- `CLR`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: start a run; sampled only in IDLE.
- `abort`, in, 1: terminate the run; returns to IDLE.
- `pause`, in, 1: freezes counting while high in RUN.
- `up`, in, 1: direction for the run (1 = count up); latched at `start`.
- `load_en`, in, 1: 1 = load `d_in` after clear; 0 = run from 0; latched at `start`.
- `d_in`, in, 4: parallel-load value; latched at `start`.
- `target`, in, W: stop value; latched at `start`.
- `q_in`, in, W: counter output `Q`.
- `cnt_clr`, out, 1: counter clear, active-high.
- `cnt_pe`, out, 1: counter parallel load, active-high.
- `cnt_en`, out, 1: counter enable (`EN_0`).
- `cnt_flag`, out, 1: counter direction (`flag`).
- `cnt_d`, out, 4: counter load data `D`.
- `busy`, out, 1: high in any state except IDLE.
- `done`, out, 1: one-cycle pulse when the target is reached.
- `run_cycles`, out, W: enabled count cycles of the last or current run; saturates at all-ones.

## Operation
- States: IDLE, CLEAR, LOAD, RUN, DONE.
- Reset (`CLR` = 0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0 and `run_cycles` goes to 0.
  - Latched `up`, `load_en`, `d_in` and `target` go to 0.
- IDLE:
  - When `start` = 1, latch `up`, `load_en`, `d_in` and `target`, clear `run_cycles`, and go to CLEAR.
- CLEAR:
  - `cnt_clr` = 1 for exactly one cycle.
  - Next state is LOAD if `load_en` = 1, otherwise RUN.
- LOAD:
  - `cnt_pe` = 1 and `cnt_d` = latched `d_in` for exactly one cycle.
  - Next state is RUN.
- RUN:
  - `cnt_en` is combinational: `cnt_en` = !`pause` && (`q_in` != `target`). This prevents overshoot.
  - When `q_in` == `target`, go to DONE.
  - `run_cycles` increments on every edge where `cnt_en` = 1.
- DONE:
  - `done` = 1 for one cycle, then IDLE.
  - `run_cycles` holds until the next `start`.
- `cnt_flag` = latched `up` in every state except IDLE, where it is 0.
- `cnt_d` = 0 outside LOAD.
- `abort` = 1 in any non-IDLE state: next state is IDLE, all counter controls are 0 from the next cycle, and `done` is not pulsed. Priority is `CLR` > `abort` > normal transitions.
- `start` is ignored while `busy` = 1.
- Wrap-around: the counter wraps modulo 2^W (FFFF→0000 up, 0000→FFFF down), so every target is reachable. No special handling is required.
- Target equal to the post-load value: RUN lasts one cycle with `cnt_en` = 0, `run_cycles` = 0, then DONE.
- `pause` is ignored outside RUN.

## Timing
- `start` at edge t:
  - CLEAR is active in cycle t+1.
  - LOAD is active in t+2 (when loading).
  - RUN begins at t+3 with load, or t+2 without load.
- Minimum run duration is 5 cycles from `start` to the return to IDLE (CLEAR, LOAD, RUN, DONE) when the target is already met.
- A run of N counts with no pause takes N+1 cycles in RUN. `done` asserts in the cycle after `q_in` first equals `target`.
- Each pause cycle adds exactly one cycle to RUN.
- All outputs are registered except `cnt_en`, which is a combinational function of the state register, `pause`, `q_in` and `target`.

## Structure
- Shared package `m16_pkg`:
  - State encoding constants `S_IDLE`…`S_DONE`.
  - Default width `W` = 16.
- One sub-module, `sat_counter`: the W-bit saturating `run_cycles` counter with sync clear and enable.
- The FSM, latches and output decode stay in the top module.
- The bench instantiates the controller with a behavioural M_16 model:
  - clear sets Q to 0;
  - load sets Q to {12'h000, D};
  - enable steps Q by ±1 per `flag`.

## Test plan
- Up run: `load_en` = 1, `d_in` = 4'h9, `up` = 1, `target` = 16'h0019 → `cnt_clr` for 1 cycle, `cnt_pe` for 1 cycle with `cnt_d` = 9, Q steps 9→0x19, `done` pulses once, `run_cycles` = 16, Q stays at 0x19.
- Down wrap: `load_en` = 0, `up` = 0, `target` = 16'hFFFD → Q 0→FFFF→FFFE→FFFD, `run_cycles` = 3, `done` after the last step.
- Pause: same as the up run with `pause` high for 4 cycles mid-RUN → Q frozen during the pause, `run_cycles` still 16, `done` delayed by exactly 4 cycles.
- Immediate target: `load_en` = 1, `d_in` = 4'h5, `target` = 16'h0005 → `cnt_en` never asserts, `run_cycles` = 0, `done` 4 cycles after `start`.
- Abort/start-while-busy: a second `start` during RUN is ignored. `abort` in RUN → IDLE next cycle, `cnt_en` = 0, no `done`, Q held at its last value.
- Reset mid-run: `CLR` = 0 for 1 cycle during RUN → all outputs 0 and `busy` = 0 after that edge. A new `start` then runs normally.
